dmem_access_sequencer: RTL
==========================

Name: dmem_access_sequencer

Overview:
- Sequences every data-memory access from the EX/MEM stage onto the single-ported, non-pipelined dmem, with a fixed read latency.
- Produces the EX/MEM load stall and returns load data to the WB path.
- Shares dmem with a secondary requester (NIC/aux port) using CPU-priority arbitration plus an anti-starvation override.
- Sits between the EX/MEM stage, the NIC buffer logic and dmem.

Parameters:
- DATA_W, 64, data width.
- ADDR_W, 16, address width.
- RD_LATENCY, 2, cycles from read issue to valid dmem_rd_data; legal range 1..3.
- STARVE_LIM, 4, consecutive denied aux cycles that force an aux grant; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cpu_mem_en  in  1  EX/MEM memory access request; held stable while cpu_stall=1
- cpu_mem_wr_en  in  1  1=store, 0=load; qualified by cpu_mem_en
- cpu_addr  in  ADDR_W  CPU address
- cpu_wr_data  in  DATA_W  store data
- cpu_stall  out  1  stall to IF/ID and ID/EXMEM; nop to EXMEM/WB
- cpu_rd_valid  out  1  load data valid this cycle
- cpu_rd_data  out  DATA_W  load data
- aux_req  in  1  aux request; held until aux_grant
- aux_wr  in  1  1=write, 0=read
- aux_addr  in  ADDR_W  aux address
- aux_wr_data  in  DATA_W  aux write data
- aux_grant  out  1  one-cycle pulse in the aux issue cycle
- aux_rd_valid  out  1  aux read data valid pulse
- aux_rd_data  out  DATA_W  aux read data
- dmem_en  out  1  dmem access enable
- dmem_wr_en  out  1  dmem write enable
- dmem_addr  out  ADDR_W  dmem address
- dmem_wr_data  out  DATA_W  dmem write data
- dmem_rd_data  in  DATA_W  dmem read data

Behaviour:
- FSM states: IDLE, CPU_RD_WAIT, AUX_RD_WAIT. Counters: wait_cnt (2 bits), starve_cnt (4 bits, saturating).
- Issue happens only in IDLE, and at most one access is issued per cycle. dmem_en, dmem_wr_en, dmem_addr and dmem_wr_data are combinational from the winning requester in the issue cycle, and 0 otherwise.
- Arbitration in IDLE:
  - Only one of CPU/aux requesting: that requester wins.
  - Both requesting: CPU wins unless starve_cnt==STARVE_LIM, in which case aux wins.
- starve_cnt: +1 each cycle with aux_req=1 and aux_grant=0; cleared on aux_grant; saturates at 15.
- Write (CPU or aux): completes in the issue cycle. No state change. No CPU stall for a granted CPU store.
- CPU load issued at cycle T:
  - Enter CPU_RD_WAIT with wait_cnt=1.
  - wait_cnt increments each cycle.
  - At T+RD_LATENCY: cpu_rd_valid=1, cpu_rd_data=dmem_rd_data (combinational pass-through), return to IDLE. No issue is allowed in this completion cycle.
- Aux read follows the same timing through AUX_RD_WAIT; completion drives aux_rd_valid and aux_rd_data.
- cpu_stall = cpu_mem_en AND NOT (CPU store issued this cycle) AND NOT (CPU load completing this cycle).
  - Load timing: stall is high T..T+RD_LATENCY-1 and low at T+RD_LATENCY. For default latency: 2 stall cycles, released on the 3rd.
- CPU request blocked by an aux read in flight, or by a starvation-forced aux grant: cpu_stall stays high until the CPU access issues.
- cpu_mem_en dropped during CPU_RD_WAIT (flush): the read still completes and cpu_rd_valid still pulses; cpu_stall=0.
- cpu_rd_data and aux_rd_data are 0 when their valid is 0.
- Reset values: state=IDLE, counters=0, all outputs 0.
- Reset mid-read: the transaction is abandoned and no valid pulse is produced.

Test Plan:
- CPU load addr 0x0010, dmem returns 0xDEADBEEF_00000001 at T+2 -> cpu_stall=1 at T and T+1, 0 at T+2; cpu_rd_valid=1 only at T+2 with that data; dmem_en high only at T.
- CPU store addr 0x0004, data 0x1122334455667788 -> dmem_en=dmem_wr_en=1 with that addr/data in the same cycle; cpu_stall=0; no state change.
- aux_req held continuously while CPU loads back-to-back, STARVE_LIM=4 -> aux_grant asserts once starve_cnt reaches 4; CPU stalls through the aux access; starve_cnt clears to 0.
- Aux read issued at T, CPU store requested at T+1 -> CPU stalled T+1..T+2; store issues at T+3; aux_rd_valid=1 at T+2.
- Reset asserted at T+1 of a CPU load -> no cpu_rd_valid; all outputs 0; next load after reset completes with normal timing.
- RD_LATENCY=1 and RD_LATENCY=3 builds -> stall width equals RD_LATENCY; rd_valid lands at T+RD_LATENCY.

Source files
------------

// File: rtl/dmem_access_sequencer_if.sv
// Bundle of the CPU (EX/MEM), aux (NIC) and dmem signals around the access sequencer.
// The sequencer takes the slave view; the surrounding pipeline, NIC and memory take the master view.
interface dmem_access_sequencer_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 16
);
  logic              cpu_mem_en;
  logic              cpu_mem_wr_en;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wr_data;
  logic              cpu_stall;
  logic              cpu_rd_valid;
  logic [DATA_W-1:0] cpu_rd_data;

  logic              aux_req;
  logic              aux_wr;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_wr_data;
  logic              aux_grant;
  logic              aux_rd_valid;
  logic [DATA_W-1:0] aux_rd_data;

  logic              dmem_en;
  logic              dmem_wr_en;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wr_data;
  logic [DATA_W-1:0] dmem_rd_data;

  modport slave (
    input  cpu_mem_en, cpu_mem_wr_en, cpu_addr, cpu_wr_data,
    output cpu_stall, cpu_rd_valid, cpu_rd_data,
    input  aux_req, aux_wr, aux_addr, aux_wr_data,
    output aux_grant, aux_rd_valid, aux_rd_data,
    output dmem_en, dmem_wr_en, dmem_addr, dmem_wr_data,
    input  dmem_rd_data
  );

  modport master (
    output cpu_mem_en, cpu_mem_wr_en, cpu_addr, cpu_wr_data,
    input  cpu_stall, cpu_rd_valid, cpu_rd_data,
    output aux_req, aux_wr, aux_addr, aux_wr_data,
    input  aux_grant, aux_rd_valid, aux_rd_data,
    input  dmem_en, dmem_wr_en, dmem_addr, dmem_wr_data,
    output dmem_rd_data
  );
endinterface

// File: rtl/dmem_access_sequencer.sv
// Serialises CPU and aux accesses onto a single-ported, fixed-latency dmem.
// CPU has priority; aux is forced through once it has been denied STARVE_LIM cycles.
module dmem_access_sequencer #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 16,
  parameter int RD_LATENCY = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_access_sequencer_if.slave bus
);

  localparam logic [1:0] RD_LAT_C = 2'(RD_LATENCY);
  localparam logic [3:0] STARVE_C = 4'(STARVE_LIM);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    CPU_RD_WAIT = 2'd1,
    AUX_RD_WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  wait_cnt_q, wait_cnt_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;

  logic              aux_win, cpu_win, cpu_done;
  logic              mem_en, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= 2'd0;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    wait_cnt_d       = wait_cnt_q;
    starve_cnt_d     = starve_cnt_q;
    aux_win          = 1'b0;
    cpu_win          = 1'b0;
    cpu_done         = 1'b0;
    mem_en           = 1'b0;
    mem_wr           = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    bus.cpu_stall    = 1'b0;
    bus.cpu_rd_valid = 1'b0;
    bus.cpu_rd_data  = '0;
    bus.aux_grant    = 1'b0;
    bus.aux_rd_valid = 1'b0;
    bus.aux_rd_data  = '0;

    // Outputs are gated during reset so an abandoned read never surfaces.
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          // The count keeps climbing while a read is in flight, so it can pass the limit.
          aux_win = bus.aux_req && (!bus.cpu_mem_en || (starve_cnt_q >= STARVE_C));
          cpu_win = bus.cpu_mem_en && !aux_win;
          if (aux_win) begin
            mem_en        = 1'b1;
            mem_wr        = bus.aux_wr;
            mem_addr      = bus.aux_addr;
            mem_wdata     = bus.aux_wr_data;
            bus.aux_grant = 1'b1;
            if (!bus.aux_wr) begin
              state_d    = AUX_RD_WAIT;
              wait_cnt_d = 2'd1;
            end
          end else if (cpu_win) begin
            mem_en    = 1'b1;
            mem_wr    = bus.cpu_mem_wr_en;
            mem_addr  = bus.cpu_addr;
            mem_wdata = bus.cpu_wr_data;
            if (!bus.cpu_mem_wr_en) begin
              state_d    = CPU_RD_WAIT;
              wait_cnt_d = 2'd1;
            end
          end
        end
        CPU_RD_WAIT: begin
          if (wait_cnt_q == RD_LAT_C) begin
            bus.cpu_rd_valid = 1'b1;
            bus.cpu_rd_data  = bus.dmem_rd_data;
            cpu_done         = 1'b1;
            state_d          = IDLE;
            wait_cnt_d       = 2'd0;
          end else begin
            wait_cnt_d = wait_cnt_q + 2'd1;
          end
        end
        AUX_RD_WAIT: begin
          if (wait_cnt_q == RD_LAT_C) begin
            bus.aux_rd_valid = 1'b1;
            bus.aux_rd_data  = bus.dmem_rd_data;
            state_d          = IDLE;
            wait_cnt_d       = 2'd0;
          end else begin
            wait_cnt_d = wait_cnt_q + 2'd1;
          end
        end
        default: begin
          state_d    = IDLE;
          wait_cnt_d = 2'd0;
        end
      endcase

      bus.cpu_stall = bus.cpu_mem_en && !(cpu_win && bus.cpu_mem_wr_en) && !cpu_done;

      if (bus.aux_grant) begin
        starve_cnt_d = 4'd0;
      end else if (bus.aux_req && (starve_cnt_q != 4'hF)) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end
  end

  assign bus.dmem_en      = mem_en;
  assign bus.dmem_wr_en   = mem_wr;
  assign bus.dmem_addr    = mem_addr;
  assign bus.dmem_wr_data = mem_wdata;

endmodule
